// File: rtl/deserializer.sv
// Serial-to-parallel receiver: start bit, PKT_W data bits LSB-first, optional even parity, stop bit.
// Optional feature: define PARITY_EN to expect an even-parity bit between the last data bit and stop.
module deserializer #(
  parameter int unsigned PKT_W = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [PKT_W-1:0] data,
  output logic             data_en,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  localparam int unsigned      BC_W     = $clog2(PKT_W + 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(PKT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;
`endif

  state_t            state;
  logic [PKT_W-1:0]  sreg;
  logic [BC_W-1:0]   bit_cnt;
  logic              frame_ok_c;

`ifdef PARITY_EN
  logic              par_bit;

  // Even parity over data plus parity bit must be zero, and stop must be low.
  always_comb begin
    frame_ok_c = 1'b0;
    frame_ok_c = !din && !(^{sreg, par_bit});
  end
`else
  always_comb begin
    frame_ok_c = 1'b0;
    frame_ok_c = !din;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      data      <= '0;
      data_en   <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      busy      <= 1'b0;
`ifdef PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      data_en   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (din) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          sreg    <= {din, sreg[PKT_W-1:1]};
          bit_cnt <= bit_cnt + BC_W'(1);
          if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          par_bit <= din;
          state   <= STOP;
        end
`endif
        STOP: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (frame_ok_c) begin
            data    <= sreg;
            data_en <= 1'b1;
            if (frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + CNT_W'(1);
          end else begin
            frame_err <= 1'b1;
            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: builds a per-cycle line/expectation schedule, then checks every cycle.
module tb_deserializer;

`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        din;
  logic [31:0] data;
  logic        data_en;
  logic        frame_err;
  logic [7:0]  frame_cnt;
  logic [7:0]  err_cnt;
  logic        busy;

  deserializer #(.PKT_W(32), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .data      (data),
    .data_en   (data_en),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Schedule: entry k is what the line/reset carry into posedge k and what the outputs show after it.
  logic        q_din[$];
  logic        q_rst[$];
  logic        q_busy[$];
  int          q_ev[$];     // 0 none, 1 good frame, 2 dropped frame
  logic [31:0] q_word[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic put(input logic d, input logic b, input int ev, input logic [31:0] w);
    q_din.push_back(d);
    q_rst.push_back(1'b0);
    q_busy.push_back(b);
    q_ev.push_back(ev);
    q_word.push_back(w);
  endtask

  task automatic put_rst(input logic d);
    q_din.push_back(d);
    q_rst.push_back(1'b1);
    q_busy.push_back(1'b0);
    q_ev.push_back(0);
    q_word.push_back(32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 1'b0, 0, 32'h0);
  endtask

  // Busy is high after the start edge through the edge before stop; the verdict appears after the stop edge.
  task automatic add_frame(input logic [31:0] w, input logic bad_stop, input logic bad_par,
                           input int gap, output int stop_idx);
    logic bad;
    bad = bad_stop || (PAR && bad_par);
    put(1'b1, 1'b1, 0, 32'h0);
    for (int i = 0; i < 32; i++) put(w[i], 1'b1, 0, 32'h0);
    if (PAR) put((^w) ^ bad_par, 1'b1, 0, 32'h0);
    stop_idx = q_din.size();
    put(bad_stop, 1'b0, bad ? 2 : 1, w);
    idle(gap);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  int idx_rst, idx_t2, idx_t3, idx_b1, idx_b2, idx_b3, idx_t5, idx_p1, idx_p2, idx_sat;

  initial begin
    logic [31:0] m_data;
    logic [7:0]  m_fc, m_ec;
    logic        m_en, m_err;
    int          dummy;

    // 1: reset held two cycles with the line high
    put_rst(1'b1);
    put_rst(1'b1);
    idx_rst = 1;
    idle(3);
    // 2: good frame
    add_frame(32'hA5C3_0F81, 1'b0, 1'b0, 2, idx_t2);
    // 3: same frame with a bad stop bit
    add_frame(32'hA5C3_0F81, 1'b1, 1'b0, 2, idx_t3);
    // 4: back-to-back, no idle gap
    add_frame(32'h0000_0001, 1'b0, 1'b0, 0, idx_b1);
    add_frame(32'hFFFF_FFFF, 1'b0, 1'b0, 0, idx_b2);
    add_frame(32'h8000_0000, 1'b0, 1'b0, 3, idx_b3);
    // 5: reset lands where D15 would be sampled, then a fresh frame
    put(1'b1, 1'b1, 0, 32'h0);
    for (int i = 0; i < 15; i++) put(1'b1, 1'b1, 0, 32'h0);
    put_rst(1'b1);
    idle(2);
    add_frame(32'h1234_5678, 1'b0, 1'b0, 2, idx_t5);
    // 6: parity flipped, then correct (without parity the flip is not on the line)
    add_frame(32'h0000_0003, 1'b0, 1'b1, 1, idx_p1);
    add_frame(32'h0000_0003, 1'b0, 1'b0, 1, idx_p2);
    // 7: enough good frames to saturate the frame counter
    for (int i = 0; i < 258; i++) add_frame(32'h0101_0101 * i ^ 32'h5A00_00A5, 1'b0, 1'b0, 0, idx_sat);
    idle(4);

    rst = 1'b1;
    din = 1'b0;
    m_data = 32'h0;
    m_fc = 8'h0;
    m_ec = 8'h0;
    m_en = 1'b0;
    m_err = 1'b0;
    dummy = 0;

    for (int k = 0; k < q_din.size(); k++) begin
      din = q_din[k];
      rst = q_rst[k];
      @(posedge clk);
      #1;
      cyc = k;
      if (q_rst[k]) begin
        m_data = 32'h0; m_fc = 8'h0; m_ec = 8'h0; m_en = 1'b0; m_err = 1'b0;
      end else begin
        m_en  = (q_ev[k] == 1);
        m_err = (q_ev[k] == 2);
        if (m_en) begin
          m_data = q_word[k];
          if (m_fc != 8'hFF) m_fc = m_fc + 8'd1;
        end
        if (m_err && m_ec != 8'hFF) m_ec = m_ec + 8'd1;
      end
      chk("data",      data,             m_data);
      chk("data_en",   32'(data_en),     32'(m_en));
      chk("frame_err", 32'(frame_err),   32'(m_err));
      chk("frame_cnt", 32'(frame_cnt),   32'(m_fc));
      chk("err_cnt",   32'(err_cnt),     32'(m_ec));
      chk("busy",      32'(busy),        32'(q_busy[k]));

      // Literal anchors for the model
      if (k == idx_rst) begin
        chk("lit_rst_data", data, 32'h0);
        chk("lit_rst_busy", 32'(busy), 32'h0);
        chk("lit_rst_cnt",  32'({frame_cnt, err_cnt, data_en, frame_err}), 32'h0);
      end
      if (k == idx_t2) begin
        chk("lit_t2_data", data, 32'hA5C3_0F81);
        chk("lit_t2_en",   32'(data_en), 32'h1);
        chk("lit_t2_fcnt", 32'(frame_cnt), 32'h1);
      end
      if (k == idx_t3) begin
        chk("lit_t3_err",  32'(frame_err), 32'h1);
        chk("lit_t3_en",   32'(data_en), 32'h0);
        chk("lit_t3_ecnt", 32'(err_cnt), 32'h1);
        chk("lit_t3_data", data, 32'hA5C3_0F81);
      end
      if (k == idx_b1) chk("lit_b1_data", data, 32'h0000_0001);
      if (k == idx_b2) chk("lit_b2_data", data, 32'hFFFF_FFFF);
      if (k == idx_b3) begin
        chk("lit_b3_data", data, 32'h8000_0000);
        chk("lit_b3_fcnt", 32'(frame_cnt), 32'h4);
      end
      if (k == idx_t5) begin
        chk("lit_t5_data", data, 32'h1234_5678);
        chk("lit_t5_fcnt", 32'(frame_cnt), 32'h1);
        chk("lit_t5_ecnt", 32'(err_cnt), 32'h0);
      end
      if (k == idx_p1) chk("lit_p1_err", 32'(frame_err), PAR ? 32'h1 : 32'h0);
      if (k == idx_p2) begin
        chk("lit_p2_en",   32'(data_en), 32'h1);
        chk("lit_p2_data", data, 32'h0000_0003);
      end
      if (k == idx_sat) chk("lit_sat_fcnt", 32'(frame_cnt), 32'hFF);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
